// File: rtl/cpu1_param_core.sv
// Parameterised single-issue toy CPU core: register file, 16-bit instruction decode,
// branch/jump with a one-cycle bubble, HALT/resume handshake and a free-running LFSR source.
module cpu1_param_core #(
    parameter int          DATA_W    = 16,
    parameter int          PC_W      = 13,
    parameter int          NUM_REGS  = 8,
    parameter logic [31:0] LFSR_INIT = 32'hABCD1000,
    parameter int          OUT_REG   = 0
) (
    input  logic              clk,
    input  logic              pon_rst_n_i,
    input  logic [15:0]       instruction,
    input  logic              instr_valid,
    output logic              instr_ready,
    input  logic              resume,
    output logic [PC_W-1:0]   pc_out,
    output logic [DATA_W-1:0] reg_data_out,
    output logic [31:0]       lfsr_out,
    output logic              cpu_halt
);

    localparam int IDX_W = $clog2(NUM_REGS);
    localparam logic [IDX_W-1:0] OUT_IDX = IDX_W'(OUT_REG);

    localparam logic [3:0] OP_NOP  = 4'd0;
    localparam logic [3:0] OP_ADD  = 4'd1;
    localparam logic [3:0] OP_SUB  = 4'd2;
    localparam logic [3:0] OP_LDI  = 4'd3;
    localparam logic [3:0] OP_JUMP = 4'd4;
    localparam logic [3:0] OP_BEQZ = 4'd5;
    localparam logic [3:0] OP_RND  = 4'd6;
    localparam logic [3:0] OP_AND  = 4'd7;
    localparam logic [3:0] OP_OR   = 4'd8;
    localparam logic [3:0] OP_XOR  = 4'd9;
    localparam logic [3:0] OP_HALT = 4'd15;

    typedef enum logic [1:0] {
        ST_RUN,
        ST_STALL,
        ST_HALT
    } state_t;

    state_t state;
    state_t state_next;

    logic [PC_W-1:0]   pc;
    logic [PC_W-1:0]   pc_next;
    logic [PC_W-1:0]   pc_inc;
    logic [PC_W-1:0]   jump_pc;
    logic [PC_W-1:0]   branch_off;
    logic [DATA_W-1:0] regs [NUM_REGS];
    logic [31:0]       lfsr;
    logic [31:0]       lfsr_next;
    logic              fire;

    logic [3:0]        opcode;
    logic [IDX_W-1:0]  rd_idx;
    logic [IDX_W-1:0]  rs1_idx;
    logic [IDX_W-1:0]  rs2_idx;
    logic [DATA_W-1:0] rd_val;
    logic [DATA_W-1:0] rs1_val;
    logic [DATA_W-1:0] rs2_val;
    logic [DATA_W-1:0] ldi_val;
    logic [DATA_W-1:0] wr_data;
    logic              wr_en;

    assign opcode  = instruction[15:12];
    assign rd_idx  = instruction[9 +: IDX_W];
    assign rs1_idx = instruction[6 +: IDX_W];
    assign rs2_idx = instruction[3 +: IDX_W];

    assign rd_val  = regs[rd_idx];
    assign rs1_val = regs[rs1_idx];
    assign rs2_val = regs[rs2_idx];

    assign instr_ready = (state == ST_RUN);
    assign cpu_halt    = (state == ST_HALT);
    assign fire        = instr_valid && instr_ready;
    assign lfsr_out    = lfsr;

    assign pc_inc    = pc + PC_W'(1);
    assign lfsr_next = {lfsr[30:0], lfsr[31] ^ lfsr[21] ^ lfsr[1] ^ lfsr[0]};

    // Jump target is zero-extended from 12 bits, branch offset sign-extended from 9 bits,
    // both fitted to whatever PC width the core is built with.
    for (genvar i = 0; i < PC_W; i++) begin : g_pc_imm
        if (i < 12) begin : g_jump_bit
            assign jump_pc[i] = instruction[i];
        end else begin : g_jump_zero
            assign jump_pc[i] = 1'b0;
        end
        if (i < 9) begin : g_off_bit
            assign branch_off[i] = instruction[i];
        end else begin : g_off_sign
            assign branch_off[i] = instruction[8];
        end
    end

    always_comb begin
        ldi_val      = '0;
        ldi_val[7:0] = instruction[7:0];
    end

    always_comb begin
        wr_en   = 1'b0;
        wr_data = '0;
        case (opcode)
            OP_ADD: begin
                wr_en   = 1'b1;
                wr_data = rs1_val + rs2_val;
            end
            OP_SUB: begin
                wr_en   = 1'b1;
                wr_data = rs1_val - rs2_val;
            end
            OP_LDI: begin
                wr_en   = 1'b1;
                wr_data = ldi_val;
            end
            OP_RND: begin
                wr_en   = 1'b1;
                wr_data = lfsr[DATA_W-1:0];
            end
            OP_AND: begin
                wr_en   = 1'b1;
                wr_data = rs1_val & rs2_val;
            end
            OP_OR: begin
                wr_en   = 1'b1;
                wr_data = rs1_val | rs2_val;
            end
            OP_XOR: begin
                wr_en   = 1'b1;
                wr_data = rs1_val ^ rs2_val;
            end
            default: begin
                wr_en   = 1'b0;
                wr_data = '0;
            end
        endcase
    end

    // Control flow: taken jumps/branches insert one bubble; HALT parks the PC until resume.
    always_comb begin
        state_next = state;
        pc_next    = pc;
        case (state)
            ST_RUN: begin
                if (fire) begin
                    case (opcode)
                        OP_JUMP: begin
                            pc_next    = jump_pc;
                            state_next = ST_STALL;
                        end
                        OP_BEQZ: begin
                            if (rd_val == '0) begin
                                pc_next    = pc + branch_off;
                                state_next = ST_STALL;
                            end else begin
                                pc_next = pc_inc;
                            end
                        end
                        OP_HALT: begin
                            state_next = ST_HALT;
                        end
                        OP_NOP: begin
                            pc_next = pc_inc;
                        end
                        default: begin
                            pc_next = pc_inc;
                        end
                    endcase
                end
            end
            ST_STALL: begin
                state_next = ST_RUN;
            end
            ST_HALT: begin
                if (resume) begin
                    state_next = ST_RUN;
                    pc_next    = pc_inc;
                end
            end
            default: begin
                state_next = ST_RUN;
            end
        endcase
    end

    always_ff @(posedge clk or negedge pon_rst_n_i) begin
        if (!pon_rst_n_i) begin
            state        <= ST_RUN;
            pc           <= '0;
            lfsr         <= LFSR_INIT;
            pc_out       <= '0;
            reg_data_out <= '0;
        end else begin
            state        <= state_next;
            pc           <= pc_next;
            if (fire) begin
                lfsr <= lfsr_next;
            end
            pc_out       <= pc;
            reg_data_out <= regs[OUT_IDX];
        end
    end

    always_ff @(posedge clk or negedge pon_rst_n_i) begin
        if (!pon_rst_n_i) begin
            for (int r = 0; r < NUM_REGS; r++) begin
                regs[r] <= '0;
            end
        end else if (fire && wr_en) begin
            regs[rd_idx] <= wr_data;
        end
    end

endmodule

// File: tb/tb_cpu1_param_core.sv
// Directed bench for cpu1_param_core: one default-width core (OUT_REG=3) and one
// 32-bit / 16-bit-PC / 4-register core (OUT_REG=1), driven on negedges.
module tb_cpu1_param_core;

    logic        clk;
    logic        rst_n;

    logic [15:0] a_instr;
    logic        a_valid;
    logic        a_resume;
    logic        a_ready;
    logic [12:0] a_pc;
    logic [15:0] a_rdo;
    logic [31:0] a_lfsr;
    logic        a_halt;

    logic [15:0] b_instr;
    logic        b_valid;
    logic        b_resume;
    logic        b_ready;
    logic [15:0] b_pc;
    logic [31:0] b_rdo;
    logic [31:0] b_lfsr;
    logic        b_halt;

    int checks;
    int errors;

    cpu1_param_core #(
        .DATA_W   (16),
        .PC_W     (13),
        .NUM_REGS (8),
        .LFSR_INIT(32'hABCD1000),
        .OUT_REG  (3)
    ) dut_a (
        .clk         (clk),
        .pon_rst_n_i (rst_n),
        .instruction (a_instr),
        .instr_valid (a_valid),
        .instr_ready (a_ready),
        .resume      (a_resume),
        .pc_out      (a_pc),
        .reg_data_out(a_rdo),
        .lfsr_out    (a_lfsr),
        .cpu_halt    (a_halt)
    );

    cpu1_param_core #(
        .DATA_W   (32),
        .PC_W     (16),
        .NUM_REGS (4),
        .LFSR_INIT(32'hABCD1000),
        .OUT_REG  (1)
    ) dut_b (
        .clk         (clk),
        .pon_rst_n_i (rst_n),
        .instruction (b_instr),
        .instr_valid (b_valid),
        .instr_ready (b_ready),
        .resume      (b_resume),
        .pc_out      (b_pc),
        .reg_data_out(b_rdo),
        .lfsr_out    (b_lfsr),
        .cpu_halt    (b_halt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic logic [15:0] rr(input logic [3:0] op, input logic [2:0] rd,
                                       input logic [2:0] rs1, input logic [2:0] rs2);
        return {op, rd, rs1, rs2, 3'b000};
    endfunction

    function automatic logic [15:0] ri(input logic [3:0] op, input logic [2:0] rd,
                                       input logic [8:0] imm);
        return {op, rd, imm};
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // Present one instruction for a single cycle; called and returns on a negedge.
    task automatic applyStimulus(input bit sel, input logic [15:0] instr);
        if (sel == 1'b0) begin
            a_instr = instr;
            a_valid = 1'b1;
        end else begin
            b_instr = instr;
            b_valid = 1'b1;
        end
        @(negedge clk);
        a_valid = 1'b0;
        b_valid = 1'b0;
    endtask

    task automatic runA(input logic [15:0] instr, input logic [15:0] exp_rdo, input string tag);
        applyStimulus(1'b0, instr);
        @(negedge clk);
        checkOutput(tag, a_rdo, exp_rdo);
    endtask

    task automatic checkResetA(input string tag);
        checkOutput({tag, "_a_pc"}, a_pc, 13'h0);
        checkOutput({tag, "_a_rdo"}, a_rdo, 16'h0);
        checkOutput({tag, "_a_lfsr"}, a_lfsr, 32'hABCD1000);
        checkOutput({tag, "_a_halt"}, a_halt, 1'b0);
        checkOutput({tag, "_a_ready"}, a_ready, 1'b1);
    endtask

    task automatic checkResetB(input string tag);
        checkOutput({tag, "_b_pc"}, b_pc, 16'h0);
        checkOutput({tag, "_b_rdo"}, b_rdo, 32'h0);
        checkOutput({tag, "_b_lfsr"}, b_lfsr, 32'hABCD1000);
        checkOutput({tag, "_b_halt"}, b_halt, 1'b0);
        checkOutput({tag, "_b_ready"}, b_ready, 1'b1);
    endtask

    task automatic pulseReset();
        rst_n = 1'b0;
        #1;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        checks   = 0;
        errors   = 0;
        rst_n    = 1'b1;
        a_instr  = '0;
        a_valid  = 1'b0;
        a_resume = 1'b0;
        b_instr  = '0;
        b_valid  = 1'b0;
        b_resume = 1'b0;

        #2 rst_n = 1'b0;
        #1;
        checkResetA("por");
        checkResetB("por");
        @(negedge clk);
        rst_n = 1'b1;

        // RND right after reset takes the pre-advance LFSR value
        applyStimulus(1'b0, ri(4'd6, 3'd5, 9'h000));
        checkOutput("rnd_lfsr", a_lfsr, 32'h579A2001);
        applyStimulus(1'b0, rr(4'd1, 3'd3, 3'd5, 3'd0));
        @(negedge clk);
        checkOutput("rnd_r5", a_rdo, 16'h1000);
        checkOutput("pc_after_two", a_pc, 13'd2);

        applyStimulus(1'b0, ri(4'd3, 3'd1, 9'd5));
        applyStimulus(1'b0, ri(4'd3, 3'd2, 9'd3));
        runA(rr(4'd2, 3'd3, 3'd1, 3'd2), 16'h0002, "sub_pos");
        runA(rr(4'd2, 3'd3, 3'd2, 3'd1), 16'hFFFE, "sub_borrow");
        runA(rr(4'd1, 3'd3, 3'd3, 3'd3), 16'hFFFC, "add_wrap_self");
        runA(rr(4'd7, 3'd3, 3'd1, 3'd2), 16'h0001, "and");
        runA(rr(4'd8, 3'd3, 3'd1, 3'd2), 16'h0007, "or");
        runA(rr(4'd9, 3'd3, 3'd1, 3'd2), 16'h0006, "xor");
        runA(rr(4'd10, 3'd3, 3'd1, 3'd2), 16'h0006, "undef_nop");
        runA(ri(4'd3, 3'd3, 9'h1AB), 16'h00AB, "ldi_zext");
        checkOutput("pc_count", a_pc, 13'd12);

        // JUMP with valid held high: exactly one bubble, then the next word is taken
        a_instr = {4'd4, 12'h100};
        a_valid = 1'b1;
        @(negedge clk);
        checkOutput("jump_bubble", a_ready, 1'b0);
        a_instr = ri(4'd3, 3'd3, 9'h077);
        @(negedge clk);
        checkOutput("jump_pc", a_pc, 13'h100);
        checkOutput("jump_ready_back", a_ready, 1'b1);
        @(negedge clk);
        a_valid = 1'b0;
        checkOutput("jump_no_second_bubble", a_ready, 1'b1);
        @(negedge clk);
        checkOutput("jump_next_exec", a_rdo, 16'h0077);
        checkOutput("jump_next_pc", a_pc, 13'h101);

        // BEQZ taken from PC 0 wraps backwards; not taken from max PC wraps forward
        pulseReset();
        applyStimulus(1'b0, ri(4'd5, 3'd4, 9'h1FE));
        checkOutput("beqz_bubble", a_ready, 1'b0);
        @(negedge clk);
        checkOutput("beqz_wrap", a_pc, 13'h1FFE);
        checkOutput("beqz_ready_back", a_ready, 1'b1);
        applyStimulus(1'b0, ri(4'd3, 3'd4, 9'd1));
        applyStimulus(1'b0, ri(4'd5, 3'd4, 9'h1FE));
        checkOutput("beqz_not_taken_ready", a_ready, 1'b1);
        @(negedge clk);
        checkOutput("pc_wrap_max", a_pc, 13'h0000);

        // HALT at PC 7 ignores valid instructions until resume
        pulseReset();
        for (int i = 0; i < 7; i++) begin
            applyStimulus(1'b0, 16'h0000);
        end
        applyStimulus(1'b0, 16'hF000);
        checkOutput("halt_flag", a_halt, 1'b1);
        checkOutput("halt_ready", a_ready, 1'b0);
        a_instr = ri(4'd3, 3'd3, 9'h055);
        a_valid = 1'b1;
        repeat (10) @(negedge clk);
        checkOutput("halt_pc_hold", a_pc, 13'd7);
        checkOutput("halt_still", a_halt, 1'b1);
        a_valid  = 1'b0;
        a_resume = 1'b1;
        @(negedge clk);
        a_resume = 1'b0;
        checkOutput("resume_halt_low", a_halt, 1'b0);
        checkOutput("resume_ready", a_ready, 1'b1);
        @(negedge clk);
        checkOutput("resume_pc", a_pc, 13'd8);
        checkOutput("halt_no_exec", a_rdo, 16'h0000);
        a_resume = 1'b1;
        @(negedge clk);
        a_resume = 1'b0;
        @(negedge clk);
        checkOutput("resume_ignored", a_pc, 13'd8);

        // Reset aborts STALL and HALT on the default core
        applyStimulus(1'b0, ri(4'd3, 3'd3, 9'h03C));
        applyStimulus(1'b0, {4'd4, 12'h020});
        checkOutput("a_in_stall", a_ready, 1'b0);
        checkOutput("a_rdo_before_rst", a_rdo, 16'h003C);
        rst_n = 1'b0;
        #1;
        checkResetA("rst_stall");
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checkOutput("a_stall_release_ready", a_ready, 1'b1);
        @(negedge clk);
        applyStimulus(1'b0, 16'hF000);
        checkOutput("a_in_halt", a_halt, 1'b1);
        rst_n = 1'b0;
        #1;
        checkResetA("rst_halt");
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checkOutput("a_halt_release_ready", a_ready, 1'b1);
        @(negedge clk);
        runA(ri(4'd3, 3'd3, 9'h011), 16'h0011, "a_post_rst_fire");

        // Wide core: 2-bit register index, 32-bit arithmetic, 16-bit PC
        applyStimulus(1'b1, ri(4'd3, 3'd5, 9'h0FF));
        @(negedge clk);
        checkOutput("b_idx_trunc", b_rdo, 32'h000000FF);
        applyStimulus(1'b1, rr(4'd2, 3'd1, 3'd0, 3'd1));
        @(negedge clk);
        checkOutput("b_sub_wrap32", b_rdo, 32'hFFFFFF01);
        applyStimulus(1'b1, {4'd4, 12'hFFF});
        checkOutput("b_jump_bubble", b_ready, 1'b0);
        @(negedge clk);
        checkOutput("b_jump_pc", b_pc, 16'h0FFF);
        applyStimulus(1'b1, {4'd4, 12'h123});
        checkOutput("b_in_stall", b_ready, 1'b0);
        rst_n = 1'b0;
        #1;
        checkResetB("rst_stall");
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checkOutput("b_stall_release_ready", b_ready, 1'b1);
        @(negedge clk);
        applyStimulus(1'b1, 16'hF000);
        checkOutput("b_in_halt", b_halt, 1'b1);
        rst_n = 1'b0;
        #1;
        checkResetB("rst_halt");
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checkOutput("b_halt_release_ready", b_ready, 1'b1);
        @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
